// File: rtl/spi_slave_rx_tx.sv
// Mode-0 SPI slave: oversamples sclk/cs/mosi in clk_i, receives bytes
// on sclk rise and shifts a buffered transmit byte out on MISO.
module spi_slave_rx_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              areset_i,
    input  logic              sclk_i,
    input  logic              cs_i,
    input  logic              mosi_i,
    output logic              miso_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_load_i,
    output logic              tx_taken_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic [DATA_W-1:0] r_tx_buf;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-2:0] r_rx_shift;
    logic [DATA_W-1:0] r_rx_data;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_reload;
    logic              r_rx_valid;
    logic              r_tx_taken;

    logic              w_sclk;
    logic              w_cs;
    logic              w_mosi;
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_cs_fall;
    logic              w_cs_rise;
    logic              w_copy;
    logic              w_rx_step;
    logic              w_tx_shift;
    logic              w_leave;
    logic              w_last;
    logic [DATA_W-1:0] w_tx_src;

    // cs idles high so the chain resets to the deselected level
    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;

    assign w_last   = (r_bit_cnt == CNT_W'(DATA_W - 1));
    assign w_tx_src = tx_load_i ? tx_data_i : r_tx_buf;

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_copy       = 1'b0;
        w_rx_step    = 1'b0;
        w_tx_shift   = 1'b0;
        w_leave      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ACTIVE;
                    w_copy       = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                    w_leave      = 1'b1;
                end else begin
                    w_rx_step = w_sclk_rise;
                    if (w_sclk_fall) begin
                        w_copy     = r_reload;
                        w_tx_shift = ~r_reload;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            r_tx_buf   <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_bit_cnt  <= '0;
            r_reload   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_taken <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_taken <= 1'b0;
            if (tx_load_i) begin
                r_tx_buf <= tx_data_i;
            end
            if (w_copy) begin
                r_tx_shift <= w_tx_src;
                r_tx_taken <= 1'b1;
                r_reload   <= 1'b0;
            end else if (w_tx_shift) begin
                r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
            end
            if (w_rx_step) begin
                r_rx_shift <= {r_rx_shift[DATA_W-3:0], w_mosi};
                if (w_last) begin
                    r_rx_data  <= {r_rx_shift, w_mosi};
                    r_rx_valid <= 1'b1;
                    r_bit_cnt  <= '0;
                    r_reload   <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end
            // partial bytes are dropped when the master deselects
            if (w_leave) begin
                r_bit_cnt <= '0;
                r_reload  <= 1'b0;
            end
        end
    end

    assign busy_o     = (r_state == ACTIVE);
    assign miso_o     = (r_state == ACTIVE) & r_tx_shift[DATA_W-1];
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
    assign tx_taken_o = r_tx_taken;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Bench for spi_slave_rx_tx: cycle-level SPI master with a byte-queue
// reference model of what the slave should receive and transmit.
module tb_spi_slave_rx_tx;

    localparam int HALF = 4;

    logic       clk_i = 1'b0;
    logic       areset_i = 1'b1;
    logic       sclk_i = 1'b0;
    logic       cs_i = 1'b1;
    logic       mosi_i = 1'b0;
    logic       miso_o;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_load_i = 1'b0;
    logic       tx_taken_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       busy_o;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] rxq[$];
    int         taken_cnt = 0;
    logic [7:0] model_buf = 8'h00;
    logic       ld_hit = 1'b0;

    spi_slave_rx_tx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk_i      (clk_i),
        .areset_i   (areset_i),
        .sclk_i     (sclk_i),
        .cs_i       (cs_i),
        .mosi_i     (mosi_i),
        .miso_o     (miso_o),
        .tx_data_i  (tx_data_i),
        .tx_load_i  (tx_load_i),
        .tx_taken_o (tx_taken_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rx_valid_o) rxq.push_back(rx_data_o);
        if (tx_taken_o) taken_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic load(input logic [7:0] v);
        tx_data_i = v;
        tx_load_i = 1'b1;
        model_buf = v;
        cyc(1);
        tx_load_i = 1'b0;
    endtask

    task automatic clear_mon();
        rxq.delete();
        taken_cnt = 0;
    endtask

    task automatic cs_lo();
        cs_i = 1'b0;
        cyc(HALF);
    endtask

    task automatic cs_hi();
        cyc(HALF);
        cs_i = 1'b1;
        cyc(2 * HALF);
    endtask

    // optional tx_load lands in the same clk as the reload copy
    task automatic xfer(input logic [7:0] mo, input int nbits,
                        input logic ld_en, input logic [7:0] ld_val,
                        output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi_i = mo[7-i];
            cyc(HALF);
            sclk_i = 1'b1;
            mi[7-i] = miso_o;
            cyc(HALF);
            sclk_i = 1'b0;
        end
        if (ld_en) begin
            cyc(2);
            tx_data_i = ld_val;
            tx_load_i = 1'b1;
            cyc(1);
            ld_hit = tx_taken_o;
            tx_load_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        areset_i = 1'b1;
        cyc(3);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy got=%b exp=0", busy_o);
        end
        n_cmp++;
        if (miso_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_miso got=%b exp=0", miso_o);
        end
        n_cmp++;
        if (rx_data_o !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rx_data got=%h exp=00", rx_data_o);
        end
        n_cmp++;
        if (rx_valid_o !== 1'b0 || tx_taken_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_pulses got=%b%b exp=00",
                     rx_valid_o, tx_taken_o);
        end
        areset_i = 1'b0;
        model_buf = 8'h00;
        cyc(4);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_busy got=%b exp=0", busy_o);
        end
    endtask

    task automatic test_basic();
        logic [7:0] mi;
        load(8'h3C);
        clear_mon();
        cs_lo();
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_busy got=%b exp=1", busy_o);
        end
        xfer(8'hA5, 8, 1'b0, 8'h00, mi);
        cs_hi();
        n_cmp++;
        if (rxq.size() !== 1) begin
            n_bad++;
            $display("FAIL basic_rx_count got=%0d exp=1", rxq.size());
        end
        n_cmp++;
        if ((rxq.size() > 0 ? rxq[0] : 8'hxx) !== 8'hA5) begin
            n_bad++;
            $display("FAIL basic_rx_data got=%h exp=a5", rx_data_o);
        end
        n_cmp++;
        if (mi !== 8'h3C) begin
            n_bad++;
            $display("FAIL basic_miso got=%h exp=3c", mi);
        end
        n_cmp++;
        if (taken_cnt !== 2) begin
            n_bad++;
            $display("FAIL basic_taken got=%0d exp=2", taken_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi0;
        logic [7:0] mi1;
        logic [7:0] first;
        first = model_buf;
        clear_mon();
        cs_lo();
        load(8'hC3);
        xfer(8'h01, 8, 1'b0, 8'h00, mi0);
        xfer(8'hFF, 8, 1'b0, 8'h00, mi1);
        cs_hi();
        n_cmp++;
        if (rxq.size() !== 2) begin
            n_bad++;
            $display("FAIL b2b_rx_count got=%0d exp=2", rxq.size());
        end
        n_cmp++;
        if ((rxq.size() > 1 ? {rxq[0], rxq[1]} : 16'hxxxx) !== 16'h01FF) begin
            n_bad++;
            $display("FAIL b2b_rx_data got_last=%h exp=01,ff", rx_data_o);
        end
        n_cmp++;
        if ({mi0, mi1} !== {first, 8'hC3}) begin
            n_bad++;
            $display("FAIL b2b_miso got=%h,%h exp=%h,c3", mi0, mi1, first);
        end
    endtask

    task automatic test_abort();
        logic [7:0] mi;
        logic [7:0] prior;
        prior = rx_data_o;
        clear_mon();
        cs_lo();
        xfer(8'hE8, 5, 1'b0, 8'h00, mi);
        cyc(HALF);
        cs_i = 1'b1;
        cyc(2);
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_busy_early got=%b exp=1", busy_o);
        end
        cyc(1);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_busy_fall got=%b exp=0", busy_o);
        end
        cyc(2 * HALF);
        n_cmp++;
        if (rxq.size() !== 0) begin
            n_bad++;
            $display("FAIL abort_no_valid got=%0d exp=0", rxq.size());
        end
        n_cmp++;
        if (rx_data_o !== prior) begin
            n_bad++;
            $display("FAIL abort_rx_hold got=%h exp=%h", rx_data_o, prior);
        end
        clear_mon();
        cs_lo();
        xfer(8'h5A, 8, 1'b0, 8'h00, mi);
        cs_hi();
        n_cmp++;
        if ((rxq.size() == 1 ? rxq[0] : 8'hxx) !== 8'h5A) begin
            n_bad++;
            $display("FAIL abort_next_rx got=%h exp=5a", rx_data_o);
        end
        n_cmp++;
        if (mi !== model_buf) begin
            n_bad++;
            $display("FAIL abort_next_miso got=%h exp=%h", mi, model_buf);
        end
    endtask

    task automatic test_retransmit();
        logic [7:0] mi0;
        logic [7:0] mi1;
        load(8'h96);
        clear_mon();
        cs_lo();
        xfer(8'h12, 8, 1'b0, 8'h00, mi0);
        xfer(8'h34, 8, 1'b0, 8'h00, mi1);
        cs_hi();
        n_cmp++;
        if ({mi0, mi1} !== 16'h9696) begin
            n_bad++;
            $display("FAIL retx_miso got=%h,%h exp=96,96", mi0, mi1);
        end
        n_cmp++;
        if (taken_cnt !== 3) begin
            n_bad++;
            $display("FAIL retx_taken got=%0d exp=3", taken_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] mi;
        load(8'hFF);
        cs_lo();
        xfer(8'hF0, 4, 1'b0, 8'h00, mi);
        #2;
        areset_i = 1'b1;
        #1;
        n_cmp++;
        if ({busy_o, miso_o, rx_valid_o, tx_taken_o} !== 4'b0000) begin
            n_bad++;
            $display("FAIL midrst_ctl got=%b%b%b%b exp=0000",
                     busy_o, miso_o, rx_valid_o, tx_taken_o);
        end
        n_cmp++;
        if (rx_data_o !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_rx_data got=%h exp=00", rx_data_o);
        end
        cs_i = 1'b1;
        mosi_i = 1'b0;
        model_buf = 8'h00;
        cyc(3);
        areset_i = 1'b0;
        cyc(4);
        clear_mon();
        cs_lo();
        xfer(8'h7E, 8, 1'b0, 8'h00, mi);
        cs_hi();
        n_cmp++;
        if ((rxq.size() == 1 ? rxq[0] : 8'hxx) !== 8'h7E) begin
            n_bad++;
            $display("FAIL midrst_next_rx got=%h exp=7e", rx_data_o);
        end
        n_cmp++;
        if (mi !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_buf_cleared got=%h exp=00", mi);
        end
    endtask

    task automatic test_load_collide();
        logic [7:0] mi0;
        logic [7:0] mi1;
        load(8'h55);
        clear_mon();
        cs_lo();
        ld_hit = 1'b0;
        xfer(8'hAB, 8, 1'b1, 8'h11, mi0);
        model_buf = 8'h11;
        xfer(8'hCD, 8, 1'b0, 8'h00, mi1);
        cs_hi();
        n_cmp++;
        if (ld_hit !== 1'b1) begin
            n_bad++;
            $display("FAIL collide_same_cycle got=%b exp=1", ld_hit);
        end
        n_cmp++;
        if ({mi0, mi1} !== 16'h5511) begin
            n_bad++;
            $display("FAIL collide_miso got=%h,%h exp=55,11", mi0, mi1);
        end
    endtask

    task automatic test_random();
        logic [7:0] expq[$];
        logic [7:0] mo;
        logic [7:0] mi;
        logic [7:0] lv;
        logic [7:0] exp_mi;
        logic       ld;
        int         nb;
        for (int s = 0; s < 12; s++) begin
            if ($urandom_range(1, 0) == 1) load(8'($urandom));
            nb = int'($urandom_range(3, 1));
            expq.delete();
            clear_mon();
            cs_lo();
            for (int b = 0; b < nb; b++) begin
                mo = 8'($urandom);
                lv = 8'($urandom);
                ld = ($urandom_range(2, 0) == 0);
                exp_mi = model_buf;
                xfer(mo, 8, ld, lv, mi);
                if (ld) model_buf = lv;
                expq.push_back(mo);
                n_cmp++;
                if (mi !== exp_mi) begin
                    n_bad++;
                    $display("FAIL rand_miso s=%0d b=%0d got=%h exp=%h",
                             s, b, mi, exp_mi);
                end
            end
            cs_hi();
            n_cmp++;
            if (rxq.size() !== nb) begin
                n_bad++;
                $display("FAIL rand_rx_count s=%0d got=%0d exp=%0d",
                         s, rxq.size(), nb);
            end
            for (int b = 0; b < nb; b++) begin
                n_cmp++;
                if ((b < rxq.size() ? rxq[b] : 8'hxx) !== expq[b]) begin
                    n_bad++;
                    $display("FAIL rand_rx s=%0d b=%0d got=%h exp=%h", s, b,
                             (b < rxq.size() ? rxq[b] : 8'hxx), expq[b]);
                end
            end
            n_cmp++;
            if (taken_cnt !== nb + 1) begin
                n_bad++;
                $display("FAIL rand_taken s=%0d got=%0d exp=%0d",
                         s, taken_cnt, nb + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_retransmit();
        test_reset_midframe();
        test_load_collide();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
